attack_sequencer: RTL and testbench
===================================

ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 The block SHALL have parameter ATTACK_KEY, default 8'h06, the keycode that requests a punch.
REQ-002 The block SHALL have parameter WINDUP_FRAMES, default 3, the number of frames in WINDUP (legal 1..255).
REQ-003 The block SHALL have parameter ACTIVE_FRAMES, default 4, the number of frames in ACTIVE (legal 1..255).
REQ-004 The block SHALL have parameter RECOVERY_FRAMES, default 8, the number of frames in RECOVERY (legal 1..255).
REQ-005 frame_clk  input  1  the single clock; every flop is on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 keycode_0..keycode_3  input  8 each  the current keyboard keycodes.
REQ-008 stun  input  1  the fighter has been hit; abort the attack.
REQ-009 punch_active  output  1  high while the punch hitbox is live; this feeds the punch-resolution stage.
REQ-010 punch_start  output  1  a one-frame pulse on the first ACTIVE frame.
REQ-011 attack_state  output  2  the state encoding: IDLE=0, WINDUP=1, ACTIVE=2, RECOVERY=3.
REQ-012 busy  output  1  high whenever attack_state != IDLE.
REQ-013 attack_count  output  8  the number of punch_start pulses, modulo 256.

Function
REQ-014 key_down SHALL be the OR of the four comparisons keycode_n == ATTACK_KEY.
REQ-015 key_down_q SHALL register key_down each frame; press = key_down & ~key_down_q.
REQ-016 A held key SHALL NOT retrigger; a new press requires a release first.
REQ-017 IDLE: if press=1 and stun=0, the next state SHALL be WINDUP and the frame counter SHALL load WINDUP_FRAMES-1.
REQ-018 In WINDUP, ACTIVE and RECOVERY, the 8-bit frame counter SHALL decrement each frame.
REQ-019 When the counter is 0, the block SHALL advance WINDUP->ACTIVE, ACTIVE->RECOVERY or RECOVERY->IDLE, loading the next phase's count minus 1.
REQ-020 Each phase SHALL therefore last exactly its parameter value in frames.
REQ-021 The first WINDUP frame SHALL be the frame after the press edge.
REQ-022 punch_active, busy and attack_state SHALL be registered and decoded directly from the state register.
REQ-023 punch_active SHALL be 1 exactly when the state is ACTIVE.
REQ-024 punch_start SHALL be 1 only on the first ACTIVE frame.
REQ-025 attack_count SHALL increment in the same frame as punch_start and wrap from 255 to 0.
REQ-026 stun=1 in any state SHALL force the next state to IDLE, clear the counter, and clear the buffer (REQ-031).
REQ-027 stun SHALL take priority over a simultaneous press.
REQ-028 A press while stun=1 SHALL be discarded, not deferred.
REQ-029 Without the buffer feature, a press in a non-IDLE state SHALL be ignored.
REQ-030 Keycodes other than ATTACK_KEY SHALL have no effect.

Configuration
REQ-031 Macro ATTACK_BUFFER_EN SHALL control input buffering.
- Defined: a press in WINDUP, ACTIVE or RECOVERY sets a 1-bit buffer. At the end of RECOVERY with the buffer set, the next state is WINDUP (not IDLE) and the buffer clears. A press while the buffer is already set has no effect.
- Undefined: no buffer flop exists and RECOVERY always returns to IDLE.

Reset
REQ-032 While Reset=1 at a clock edge, the block SHALL set state=IDLE, counter=0, attack_count=0 and buffer=0.
REQ-033 While Reset=1 at a clock edge, punch_active, punch_start and busy SHALL be 0, and attack_state SHALL be 0.
REQ-034 During reset, key_down_q SHALL load key_down, so a key held across reset does not fire.
REQ-035 Reset asserted mid-attack SHALL abort the attack; attack_count does not increment.

Verification
REQ-036 Defaults; keycode_2=8'h06 for 1 frame -> 3 frames WINDUP, punch_active=1 for 4 frames, 8 frames RECOVERY, IDLE, attack_count=1.
REQ-037 Key held for 40 frames -> exactly one attack and one punch_start.
REQ-038 stun=1 on the 2nd ACTIVE frame -> IDLE next frame, punch_active=0, attack_count unchanged.
REQ-039 Reset released with keycode_0=8'h06 held -> no attack until the key is released and pressed again.
REQ-040 Press at RECOVERY frame 5 -> with ATTACK_BUFFER_EN: RECOVERY->WINDUP directly and attack_count=2. Without it: IDLE and attack_count=1.
REQ-041 256 attacks -> attack_count wraps to 0.

Source files
------------

// File: rtl/attack_sequencer.sv
// attack_sequencer: punch FSM (WINDUP/ACTIVE/RECOVERY) with optional press buffering via ATTACK_BUFFER_EN
module attack_sequencer #(
  parameter logic [7:0] ATTACK_KEY      = 8'h06,
  parameter int         WINDUP_FRAMES   = 3,
  parameter int         ACTIVE_FRAMES   = 4,
  parameter int         RECOVERY_FRAMES = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  input  logic       stun,
  output logic       punch_active,
  output logic       punch_start,
  output logic [1:0] attack_state,
  output logic       busy,
  output logic [7:0] attack_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, WINDUP = 2'd1, ACTIVE = 2'd2, RECOVERY = 2'd3} state_t;
  localparam logic [7:0] W_LOAD = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0] A_LOAD = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0] R_LOAD = 8'(RECOVERY_FRAMES - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_count;
  logic       r_kq;
  logic       r_start;
  logic       w_key;
  logic       w_press;
  logic       w_rearm;
  assign w_key   = (keycode_0 == ATTACK_KEY) | (keycode_1 == ATTACK_KEY) |
                   (keycode_2 == ATTACK_KEY) | (keycode_3 == ATTACK_KEY);
  assign w_press = w_key & ~r_kq;
`ifdef ATTACK_BUFFER_EN
  logic r_buf;
  // A press inside an attack is remembered so RECOVERY chains straight into WINDUP;
  // a press on the very last RECOVERY frame is honoured through w_rearm directly.
  always_ff @(posedge frame_clk) begin
    if (Reset || stun) r_buf <= 1'b0;
    else if (r_state == RECOVERY && r_cnt == 8'd0) r_buf <= 1'b0;
    else if (r_state != IDLE && w_press) r_buf <= 1'b1;
  end
  assign w_rearm = r_buf | w_press;
`else
  assign w_rearm = 1'b0;
`endif
  // Edge detector follows the keys even in reset so a key held through reset cannot fire.
  always_ff @(posedge frame_clk) r_kq <= w_key;
  // Phase sequencing: each phase loads its length minus one and advances when the counter hits zero.
  always_ff @(posedge frame_clk) begin
    r_start <= 1'b0;
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_count <= 8'd0;
    end else if (stun) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else if (r_state == IDLE) begin
      if (w_press) begin
        r_state <= WINDUP;
        r_cnt   <= W_LOAD;
      end
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end else if (r_state == WINDUP) begin
      r_state <= ACTIVE;
      r_cnt   <= A_LOAD;
      r_start <= 1'b1;
      r_count <= r_count + 8'd1;
    end else if (r_state == ACTIVE) begin
      r_state <= RECOVERY;
      r_cnt   <= R_LOAD;
    end else begin
      r_state <= w_rearm ? WINDUP : IDLE;
      r_cnt   <= w_rearm ? W_LOAD : 8'd0;
    end
  end
  assign punch_active = r_state == ACTIVE;
  assign busy         = r_state != IDLE;
  assign attack_state = r_state;
  assign punch_start  = r_start;
  assign attack_count = r_count;
endmodule

// File: tb/tb_attack_sequencer.sv
// tb_attack_sequencer: random and directed frames checked against a timeline model of the punch
module tb_attack_sequencer;
  localparam int W = 3, A = 4, R = 8, T = W + A + R;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kc0, kc1, kc2, kc3;
  logic       stun;
  logic       punch_active, punch_start, busy;
  logic [1:0] attack_state;
  logic [7:0] attack_count;
  int n_checks = 0, n_fail = 0;
  int frame_no = 0, start = -1, m_count = 0;
  bit m_kq = 1'b0, m_buf = 1'b0;
  attack_sequencer dut (
    .frame_clk(clk), .Reset(rst),
    .keycode_0(kc0), .keycode_1(kc1), .keycode_2(kc2), .keycode_3(kc3),
    .stun(stun), .punch_active(punch_active), .punch_start(punch_start),
    .attack_state(attack_state), .busy(busy), .attack_count(attack_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s frame %0d: got %0d expected %0d", tag, frame_no, got, exp);
    end
  endtask
  function automatic int phase_of(input int age);
    return age < W ? 1 : age < W + A ? 2 : 3;
  endfunction
  function automatic logic [7:0] other_key();
    logic [7:0] v = 8'($urandom_range(0, 255));
    return v == 8'h06 ? 8'h07 : v;
  endfunction
  task automatic frame(input bit key, input int slot, input bit s, input bit r);
    bit kd, press;
    int age, exp_state;
    kc0 = other_key(); kc1 = other_key(); kc2 = other_key(); kc3 = other_key();
    if (key) begin
      if (slot == 0) kc0 = 8'h06;
      else if (slot == 1) kc1 = 8'h06;
      else if (slot == 2) kc2 = 8'h06;
      else kc3 = 8'h06;
    end
    stun = s; rst = r;
    kd = key;
    @(posedge clk);
    press = kd & ~m_kq;
    m_kq = kd;
    if (r) begin
      start = -1; m_buf = 1'b0; m_count = 0;
    end else if (s) begin
      start = -1; m_buf = 1'b0;
    end else if (start < 0) begin
      if (press) start = frame_no + 1;
    end else begin
      age = frame_no - start;
`ifdef ATTACK_BUFFER_EN
      m_buf = m_buf | press;
`endif
      if (age == W - 1) m_count = (m_count + 1) % 256;
      if (age == T - 1) begin
        start = m_buf ? frame_no + 1 : -1;
        m_buf = 1'b0;
      end
    end
    frame_no++;
    #1;
    exp_state = start < 0 ? 0 : phase_of(frame_no - start);
    check("state", int'(attack_state), exp_state);
    check("busy", int'(busy), int'(exp_state != 0));
    check("punch_active", int'(punch_active), int'(exp_state == 2));
    check("punch_start", int'(punch_start), int'(start >= 0 && frame_no - start == W));
    check("attack_count", int'(attack_count), m_count);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 0, 1'b0, 1'b0);
  endtask
  initial begin
    kc0 = 0; kc1 = 0; kc2 = 0; kc3 = 0; stun = 0; rst = 1;
    frame(1'b0, 0, 1'b0, 1'b1);
    frame(1'b0, 0, 1'b0, 1'b1);
    idle(2);
    frame(1'b1, 2, 1'b0, 1'b0);
    idle(T + 3);
    check("single_attack_count", int'(attack_count), 1);
    for (int i = 0; i < 40; i++) frame(1'b1, i % 4, 1'b0, 1'b0);
    idle(5);
    check("held_key_count", int'(attack_count), 2);
    frame(1'b1, 1, 1'b0, 1'b0);
    idle(W + 1);
    frame(1'b0, 0, 1'b1, 1'b0);
    check("stun_abort_active", int'(punch_active), 0);
    check("stun_abort_count", int'(attack_count), 3);
    idle(3);
    frame(1'b1, 0, 1'b1, 1'b0);
    idle(3);
    check("press_during_stun_dropped", int'(busy), 0);
    frame(1'b1, 0, 1'b0, 1'b1);
    frame(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) frame(1'b1, 0, 1'b0, 1'b0);
    check("held_through_reset", int'(busy), 0);
    idle(1);
    frame(1'b1, 3, 1'b0, 1'b0);
    idle(W + A + 4);
    frame(1'b1, 3, 1'b0, 1'b0);
    idle(R - 4);
`ifdef ATTACK_BUFFER_EN
    check("buffered_rearm_state", int'(attack_state), 1);
    idle(W + 1);
    check("buffered_rearm_count", int'(attack_count), 2);
`else
    check("unbuffered_idle_state", int'(attack_state), 0);
    idle(W + 1);
    check("unbuffered_count", int'(attack_count), 1);
`endif
    idle(T + 2);
    for (int i = 0; i < 3000; i++) begin
      int dice = $urandom_range(0, 99);
      frame(dice < 45, $urandom_range(0, 3), dice >= 97, dice == 96);
    end
    frame(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      frame(1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
      idle(T + 1);
    end
    check("count_wrap", int'(attack_count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
